// File: rtl/count_time_pkg.sv
// Shared constants, packed time type and load-validity helper for the HH:MM counter.
package count_time_pkg;

    localparam int MIN_U_MAX        = 9;
    localparam int MIN_Z_MAX        = 5;
    localparam int HOUR_U_MAX       = 9;
    localparam int HOUR_Z_MAX       = 2;
    localparam int HOUR_U_MAX_AT_Z2 = 3;

    typedef struct packed {
        logic [1:0] z_hour;
        logic [3:0] u_hour;
        logic [2:0] z_min;
        logic [3:0] u_min;
    } time_t;

    // A load is honoured only for a real 00:00..23:59 time.
    function automatic logic time_is_valid(input time_t t);
        return (t.u_min <= 4'(MIN_U_MAX))
            && (t.z_min <= 3'(MIN_Z_MAX))
            && (t.u_hour <= 4'(HOUR_U_MAX))
            && (t.z_hour <= 2'(HOUR_Z_MAX))
            && ((t.z_hour != 2'(HOUR_Z_MAX)) || (t.u_hour <= 4'(HOUR_U_MAX_AT_Z2)));
    endfunction

endpackage

// File: rtl/count_time_digit.sv
// Modulo-(MAX+1) BCD digit with synchronous clear (rst_n), load and increment-with-carry.
module count_time_digit #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc_in,
    output logic [WIDTH-1:0] digit,
    output logic             carry_out
);

    logic [WIDTH-1:0] digit_reg;

    // Carry is combinational so the next digit can advance on the same edge.
    assign carry_out = inc_in && (digit_reg == WIDTH'(MAX));
    assign digit     = digit_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_reg <= '0;
        end else if (load) begin
            digit_reg <= load_val;
        end else if (inc_in) begin
            digit_reg <= carry_out ? '0 : digit_reg + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_time.sv
// 24-hour BCD HH:MM counter with prescaler and validated parallel load.
// Optional day_wrap pulse on 23:59 -> 00:00 is built when COUNT_TIME_DAY_WRAP_EN is defined.
module count_time
    import count_time_pkg::*;
#(
    parameter int TICKS_PER_MIN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] u_min_in,
    input  logic [2:0] z_min_in,
    input  logic [3:0] u_hour_in,
    input  logic [1:0] z_hour_in,
    output logic [3:0] u_min_out,
    output logic [2:0] z_min_out,
    output logic [3:0] u_hour_out,
    output logic [1:0] z_hour_out,
    output logic       day_wrap
);

    localparam int PRESC_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;

    time_t              load_time;
    logic               load_ok;
    logic               tick;
    logic               min_inc;
    logic               u_min_carry;
    logic               min_carry;
    logic               hour_at_max;
    logic [PRESC_W-1:0] presc_reg;
    logic [3:0]         u_hour_reg;
    logic [1:0]         z_hour_reg;

    assign load_time = '{z_hour: z_hour_in, u_hour: u_hour_in, z_min: z_min_in, u_min: u_min_in};
    assign load_ok   = load && time_is_valid(load_time);
    assign tick      = en && (presc_reg == PRESC_W'(TICKS_PER_MIN - 1));
    // A valid load suppresses the increment for that edge.
    assign min_inc   = tick && !load_ok;

    always_ff @(posedge clk) begin
        if (!rst_n || load_ok) begin
            presc_reg <= '0;
        end else if (en) begin
            presc_reg <= tick ? '0 : presc_reg + PRESC_W'(1);
        end
    end

    count_time_digit #(.WIDTH(4), .MAX(MIN_U_MAX)) u_min_digit (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_ok),
        .load_val  (u_min_in),
        .inc_in    (min_inc),
        .digit     (u_min_out),
        .carry_out (u_min_carry)
    );

    count_time_digit #(.WIDTH(3), .MAX(MIN_Z_MAX)) z_min_digit (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_ok),
        .load_val  (z_min_in),
        .inc_in    (u_min_carry),
        .digit     (z_min_out),
        .carry_out (min_carry)
    );

    // Hours are kept as a pair because the units limit depends on the tens digit.
    assign hour_at_max = (z_hour_reg == 2'(HOUR_Z_MAX)) && (u_hour_reg == 4'(HOUR_U_MAX_AT_Z2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            u_hour_reg <= '0;
            z_hour_reg <= '0;
        end else if (load_ok) begin
            u_hour_reg <= u_hour_in;
            z_hour_reg <= z_hour_in;
        end else if (min_carry) begin
            if (hour_at_max) begin
                u_hour_reg <= '0;
                z_hour_reg <= '0;
            end else if (u_hour_reg == 4'(HOUR_U_MAX)) begin
                u_hour_reg <= '0;
                z_hour_reg <= z_hour_reg + 2'd1;
            end else begin
                u_hour_reg <= u_hour_reg + 4'd1;
            end
        end
    end

    assign u_hour_out = u_hour_reg;
    assign z_hour_out = z_hour_reg;

`ifdef COUNT_TIME_DAY_WRAP_EN
    logic day_wrap_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            day_wrap_reg <= 1'b0;
        end else begin
            day_wrap_reg <= min_carry && hour_at_max;
        end
    end

    assign day_wrap = day_wrap_reg;
`else
    assign day_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_count_time.sv
// Bench for count_time: table vectors, hand sequences and random traffic against a
// minutes-of-day reference model; runs one DUT with TICKS_PER_MIN=1 and one with 4.
module tb_count_time;

`ifdef COUNT_TIME_DAY_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, en, load;
    logic [3:0] u_min_in, u_hour_in;
    logic [2:0] z_min_in;
    logic [1:0] z_hour_in;

    logic [3:0] a_u_min, a_u_hour, b_u_min, b_u_hour;
    logic [2:0] a_z_min, b_z_min;
    logic [1:0] a_z_hour, b_z_hour;
    logic       a_wrap, b_wrap;

    int total = 0;
    int bad   = 0;

    // Reference state per DUT: index 0 -> TICKS_PER_MIN=1, index 1 -> TICKS_PER_MIN=4.
    int m_min  [2];
    int m_pre  [2];
    bit m_wrap [2];
    int m_tpm  [2] = '{1, 4};

    always #5 clk = ~clk;

    count_time #(.TICKS_PER_MIN(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .u_min_in(u_min_in), .z_min_in(z_min_in), .u_hour_in(u_hour_in), .z_hour_in(z_hour_in),
        .u_min_out(a_u_min), .z_min_out(a_z_min), .u_hour_out(a_u_hour), .z_hour_out(a_z_hour),
        .day_wrap(a_wrap)
    );

    count_time #(.TICKS_PER_MIN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .u_min_in(u_min_in), .z_min_in(z_min_in), .u_hour_in(u_hour_in), .z_hour_in(z_hour_in),
        .u_min_out(b_u_min), .z_min_out(b_z_min), .u_hour_out(b_u_hour), .z_hour_out(b_z_hour),
        .day_wrap(b_wrap)
    );

    typedef struct {
        bit       rst_n;
        bit       en;
        bit       load;
        int       hh;
        int       mm;
        int       exp_min;
        bit       exp_wrap;
    } vec_t;

    function automatic int hm(input int h, input int m);
        return h * 60 + m;
    endfunction

    // Load digits describe a real time only if minutes < 60 and hours < 24.
    function automatic bit model_valid();
        int mins, hours;
        if (u_min_in > 9 || u_hour_in > 9) return 1'b0;
        mins  = int'(z_min_in) * 10 + int'(u_min_in);
        hours = int'(z_hour_in) * 10 + int'(u_hour_in);
        return (mins < 60) && (hours < 24);
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 1'b0;
            if (!rst_n) begin
                m_min[k] = 0;
                m_pre[k] = 0;
            end else if (load && model_valid()) begin
                m_min[k] = (int'(z_hour_in) * 10 + int'(u_hour_in)) * 60
                         + int'(z_min_in) * 10 + int'(u_min_in);
                m_pre[k] = 0;
            end else if (en) begin
                if (m_pre[k] == m_tpm[k] - 1) begin
                    m_pre[k]  = 0;
                    m_wrap[k] = (m_min[k] == 1439);
                    m_min[k]  = (m_min[k] + 1) % 1440;
                end else begin
                    m_pre[k]++;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [1:0] zh, input logic [3:0] uh,
                         input logic [2:0] zm, input logic [3:0] um, input logic w,
                         input int exp_m, input bit exp_w);
        int  ezh, euh, ezm, eum;
        bit  ew;
        ezh = exp_m / 600;
        euh = (exp_m / 60) % 10;
        ezm = (exp_m % 60) / 10;
        eum = exp_m % 10;
        ew  = WRAP_EN && exp_w;
        total++;
        if (int'(zh) !== ezh || int'(uh) !== euh || int'(zm) !== ezm || int'(um) !== eum
            || w !== ew) begin
            bad++;
            $display("FAIL %s: got %0d%0d:%0d%0d wrap=%0b, want %0d%0d:%0d%0d wrap=%0b",
                     name, zh, uh, zm, um, w, ezh, euh, ezm, eum, ew);
        end else begin
            $display("ok   %s: %0d%0d:%0d%0d wrap=%0b", name, zh, uh, zm, um, w);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit l, input int hh, input int mm);
        @(negedge clk);
        rst_n     = r;
        en        = e;
        load      = l;
        z_hour_in = 2'(hh / 10);
        u_hour_in = 4'(hh % 10);
        z_min_in  = 3'(mm / 10);
        u_min_in  = 4'(mm % 10);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_b_model(input string name);
        check(name, b_z_hour, b_u_hour, b_z_min, b_u_min, b_wrap, m_min[1], m_wrap[1]);
    endtask

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        u_min_in = '0; z_min_in = '0; u_hour_in = '0; z_hour_in = '0;

        vecs.push_back('{0, 0, 0,  0,  0, hm( 0,  0), 0});  // reset
        vecs.push_back('{1, 1, 0,  0,  0, hm( 0,  1), 0});
        vecs.push_back('{1, 1, 0,  0,  0, hm( 0,  2), 0});
        vecs.push_back('{1, 1, 0,  0,  0, hm( 0,  3), 0});
        vecs.push_back('{1, 1, 1, 28, 53, hm( 0,  4), 0});  // invalid hour, keeps counting
        vecs.push_back('{1, 1, 1, 24,  0, hm( 0,  5), 0});  // 24:00 invalid
        vecs.push_back('{1, 1, 1, 23, 58, hm(23, 58), 0});  // load wins over tick
        vecs.push_back('{1, 1, 0,  0,  0, hm(23, 59), 0});
        vecs.push_back('{1, 1, 0,  0,  0, hm( 0,  0), 1});  // day wrap
        vecs.push_back('{1, 1, 0,  0,  0, hm( 0,  1), 0});
        vecs.push_back('{1, 0, 1,  9, 59, hm( 9, 59), 0});
        vecs.push_back('{1, 1, 0,  0,  0, hm(10,  0), 0});
        vecs.push_back('{1, 0, 1, 19, 59, hm(19, 59), 0});
        vecs.push_back('{1, 1, 0,  0,  0, hm(20,  0), 0});
        vecs.push_back('{1, 0, 1, 12,  9, hm(12,  9), 0});
        vecs.push_back('{1, 1, 0,  0,  0, hm(12, 10), 0});
        vecs.push_back('{1, 0, 1, 14, 37, hm(14, 37), 0});
        for (int i = 0; i < 5; i++) vecs.push_back('{1, 0, 0, 0, 0, hm(14, 37), 0});
        vecs.push_back('{1, 0, 1,  5,  5, hm( 5,  5), 0});
        vecs.push_back('{1, 0, 0,  0,  0, hm( 5,  5), 0});
        vecs.push_back('{1, 1, 1,  5, 60, hm( 5,  6), 0});  // minute tens 6 invalid
        vecs.push_back('{1, 1, 1, 23, 59, hm(23, 59), 0});
        vecs.push_back('{0, 1, 1, 12, 34, hm( 0,  0), 0});  // reset beats load

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].load, vecs[i].hh, vecs[i].mm);
            check($sformatf("vec%0d", i), a_z_hour, a_u_hour, a_z_min, a_u_min, a_wrap,
                  vecs[i].exp_min, vecs[i].exp_wrap);
            check_b_model($sformatf("vec%0d_t4", i));
        end

        // Prescaler of 4: minute advances on the fourth enabled edge.
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 0, 0, 0);
            check($sformatf("t4_edge%0d", i), b_z_hour, b_u_hour, b_z_min, b_u_min, b_wrap,
                  (i == 4) ? 1 : 0, 0);
        end
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);  // reset mid-count
        check("t4_midreset", b_z_hour, b_u_hour, b_z_min, b_u_min, b_wrap, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 0, 0, 0);
            check($sformatf("t4_after_rst%0d", i), b_z_hour, b_u_hour, b_z_min, b_u_min, b_wrap,
                  (i == 4) ? 1 : 0, 0);
        end
        // Load clears a partly-filled prescaler.
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 1, 23, 59);
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 0, 0, 0);
            check($sformatf("t4_wrap%0d", i), b_z_hour, b_u_hour, b_z_min, b_u_min, b_wrap,
                  (i == 4) ? 0 : hm(23, 59), i == 4);
        end

        // Random traffic, biased toward loads near midnight.
        for (int i = 0; i < 600; i++) begin
            bit r, e, l;
            int hh, mm;
            r  = ($urandom_range(0, 59) != 0);
            e  = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 11) == 0);
            hh = ($urandom_range(0, 1) != 0) ? 23 : int'($urandom_range(0, 29));
            mm = ($urandom_range(0, 1) != 0) ? int'($urandom_range(56, 59))
                                             : int'($urandom_range(0, 69));
            drive(r, e, l, hh, mm);
            check($sformatf("rnd%0d", i), a_z_hour, a_u_hour, a_z_min, a_u_min, a_wrap,
                  m_min[0], m_wrap[0]);
            check_b_model($sformatf("rnd%0d_t4", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
